// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: instruction FIFO, operand fetch and writeback around a combinational ALU.
// Optional feature macro RETIRE_CNT_EN adds the retire_cnt output.

module alu_issue_ctrl #(
   parameter int FIFO_DEPTH = 4,
   parameter int ALU_LAT    = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        in_valid,
   input  logic [31:0] in_instr,
   output logic        in_ready,
   output logic [31:0] alu_instr,
   output logic [31:0] alu_gr1,
   input  logic [31:0] alu_result,
   output logic        wb_valid,
   output logic [4:0]  wb_addr,
   output logic [31:0] wb_data,
   output logic        err_illegal,
   input  logic        cfg_we,
   input  logic [4:0]  cfg_addr,
   input  logic [31:0] cfg_data,
   input  logic [4:0]  dbg_addr,
   output logic [31:0] dbg_data,
`ifdef RETIRE_CNT_EN
   output logic [31:0] retire_cnt,
`endif
   output logic        busy
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam int LW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

   localparam logic [PW-1:0] P_ONE  = 1;
   localparam logic [CW-1:0] C_ONE  = 1;
   localparam logic [CW-1:0] C_FULL = CW'(FIFO_DEPTH);
   localparam logic [LW-1:0] L_ONE  = 1;
   localparam logic [LW-1:0] L_LAST = LW'(ALU_LAT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_WB
   } state_t;

   logic [31:0]   r_mem [FIFO_DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;

   state_t        r_state;
   logic [31:0]   r_cur;
   logic [LW-1:0] r_cnt;
   logic [31:0]   r_alu_instr;
   logic [31:0]   r_alu_gr1;
   logic          r_wb_valid;
   logic [4:0]    r_wb_addr;
   logic [31:0]   r_wb_data;
   logic          r_err;

   logic [31:0]   r_rf [32];

   logic          w_empty;
   logic          w_full;
   logic          w_push;
   logic          w_pop;
   logic          w_illegal;
   logic          w_shift;
   logic [4:0]    w_src;

   assign w_empty   = (r_count == '0);
   assign w_full    = (r_count == C_FULL);
   assign w_push    = in_valid && !w_full;
   assign w_illegal = (r_cur[31:26] != 6'd0);
   assign w_shift   = (r_cur[5:0] == 6'b000000) ||
                      (r_cur[5:0] == 6'b000010) ||
                      (r_cur[5:0] == 6'b000011);
   assign w_src     = w_shift ? r_cur[20:16] : r_cur[25:21];

   // The FSM takes the FIFO head whenever it is ready for a new instruction
   assign w_pop = !w_empty &&
                  ((r_state == S_IDLE) ||
                   (r_state == S_WB) ||
                   ((r_state == S_ISSUE) && w_illegal));

   // FIFO storage; contents need no reset since the pointers gate them
   always_ff @(posedge clock) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= in_instr;
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clock) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + P_ONE;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + P_ONE;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + C_ONE;
            2'b01:   r_count <= r_count - C_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   // Issue FSM with registered ALU drive, writeback and error outputs
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_cur       <= '0;
         r_cnt       <= '0;
         r_alu_instr <= '0;
         r_alu_gr1   <= '0;
         r_wb_valid  <= 1'b0;
         r_wb_addr   <= '0;
         r_wb_data   <= '0;
         r_err       <= 1'b0;
      end else begin
         r_err      <= 1'b0;
         r_wb_valid <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (w_pop) begin
                  r_cur   <= r_mem[r_rd_ptr];
                  r_state <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (w_illegal) begin
                  r_err <= 1'b1;
                  if (w_pop) begin
                     r_cur   <= r_mem[r_rd_ptr];
                     r_state <= S_ISSUE;
                  end else begin
                     r_state <= S_IDLE;
                  end
               end else begin
                  r_alu_instr <= r_cur;
                  r_alu_gr1   <= r_rf[w_src];
                  r_cnt       <= '0;
                  r_state     <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (r_cnt == L_LAST) begin
                  r_wb_valid <= 1'b1;
                  r_wb_addr  <= r_cur[15:11];
                  r_wb_data  <= alu_result;
                  r_state    <= S_WB;
               end else begin
                  r_cnt <= r_cnt + L_ONE;
               end
            end
            S_WB: begin
               if (w_pop) begin
                  r_cur   <= r_mem[r_rd_ptr];
                  r_state <= S_ISSUE;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Register file: preload first, writeback last so writeback wins; r0 never written
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) begin
            r_rf[i] <= '0;
         end
      end else begin
         if (cfg_we && (cfg_addr != 5'd0)) begin
            r_rf[cfg_addr] <= cfg_data;
         end
         if (r_wb_valid && (r_wb_addr != 5'd0)) begin
            r_rf[r_wb_addr] <= r_wb_data;
         end
      end
   end

`ifdef RETIRE_CNT_EN
   logic [31:0] r_retire;

   // Count completed writebacks; dropped instructions never reach WB
   always_ff @(posedge clock) begin
      if (reset) begin
         r_retire <= '0;
      end else if (r_wb_valid) begin
         r_retire <= r_retire + 32'd1;
      end
   end

   assign retire_cnt = r_retire;
`endif

   assign in_ready    = !w_full;
   assign alu_instr   = r_alu_instr;
   assign alu_gr1     = r_alu_gr1;
   assign wb_valid    = r_wb_valid;
   assign wb_addr     = r_wb_addr;
   assign wb_data     = r_wb_data;
   assign err_illegal = r_err;
   assign dbg_data    = r_rf[dbg_addr];
   assign busy        = (r_state != S_IDLE) || !w_empty;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: table vectors, directed corner sequences and random stream
// checked against an in-order ISA-level model of the issue controller.

module tb_alu_issue_ctrl;

   localparam int DEPTH = 4;
   localparam int LAT   = 3;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid;
   logic [31:0] in_instr;
   logic        in_ready;
   logic [31:0] alu_instr;
   logic [31:0] alu_gr1;
   logic [31:0] alu_result;
   logic        wb_valid;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        err_illegal;
   logic        cfg_we;
   logic [4:0]  cfg_addr;
   logic [31:0] cfg_data;
   logic [4:0]  dbg_addr;
   logic [31:0] dbg_data;
   logic        busy;
`ifdef RETIRE_CNT_EN
   logic [31:0] retire_cnt;
`endif

   typedef struct {
      logic [31:0] r1;
      logic [31:0] instr;
      logic        ill;
      logic [4:0]  addr;
      logic [31:0] data;
      logic [31:0] gr1;
   } vec_t;

   vec_t        tbl [7];
   int          checks = 0;
   int          errors = 0;
   logic [31:0] m_rf [32];
   logic [31:0] q_acc [$];
   logic        pend_wb = 1'b0;
   logic [4:0]  pend_addr;
   logic [31:0] pend_data;
   int          cyc = 0;
   int          n_wb = 0;
   int          n_ret = 0;
   logic [31:0] alu_i_q = '0;
   logic [31:0] alu_g_q = '0;
   int          stab = 0;

   alu_issue_ctrl #(
      .FIFO_DEPTH(DEPTH),
      .ALU_LAT   (LAT)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_instr   (in_instr),
      .in_ready   (in_ready),
      .alu_instr  (alu_instr),
      .alu_gr1    (alu_gr1),
      .alu_result (alu_result),
      .wb_valid   (wb_valid),
      .wb_addr    (wb_addr),
      .wb_data    (wb_data),
      .err_illegal(err_illegal),
      .cfg_we     (cfg_we),
      .cfg_addr   (cfg_addr),
      .cfg_data   (cfg_data),
      .dbg_addr   (dbg_addr),
      .dbg_data   (dbg_data),
`ifdef RETIRE_CNT_EN
      .retire_cnt (retire_cnt),
`endif
      .busy       (busy)
   );

   initial forever #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   function automatic logic [31:0] alu_ref(input logic [31:0] ins,
                                           input logic [31:0] g);
      case (ins[5:0])
         6'd0:    return g << ins[10:6];
         6'd2:    return g >> ins[10:6];
         6'd3:    return $signed(g) >>> ins[10:6];
         default: return ~g;
      endcase
   endfunction

   function automatic logic [4:0] src_of(input logic [31:0] ins);
      if (ins[5:0] == 6'd0 || ins[5:0] == 6'd2 || ins[5:0] == 6'd3)
         return ins[20:16];
      return ins[25:21];
   endfunction

   // Behavioural ALU: only settles after LAT cycles of stable inputs
   always @(negedge clock) begin
      if (alu_instr == alu_i_q && alu_gr1 == alu_g_q) stab = stab + 1;
      else stab = 1;
      alu_i_q = alu_instr;
      alu_g_q = alu_gr1;
   end

   assign alu_result = (stab >= LAT) ? alu_ref(alu_instr, alu_gr1)
                                     : 32'hDEADBEEF;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // Model state: accepted stream, architectural registers, retire count
   always @(posedge clock) begin
      cyc++;
      if (reset) begin
         q_acc.delete();
         for (int i = 0; i < 32; i++) m_rf[i] = '0;
         pend_wb = 1'b0;
         n_ret = 0;
      end else begin
         if (in_valid && in_ready) q_acc.push_back(in_instr);
         if (wb_valid) n_ret++;
         if (cfg_we && cfg_addr != 5'd0) m_rf[cfg_addr] = cfg_data;
         if (pend_wb) begin
            if (pend_addr != 5'd0) m_rf[pend_addr] = pend_data;
            pend_wb = 1'b0;
         end
      end
   end

   // In-order checker: every pulse retires the oldest accepted word
   always @(negedge clock) begin : mon
      logic [31:0] ins;
      logic [31:0] e;
      if (!reset) begin
         if (wb_valid) begin
            n_wb++;
            if (q_acc.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL mdl_wb_unexpected actual=1 required=0");
            end else begin
               ins = q_acc.pop_front();
               e = alu_ref(ins, m_rf[src_of(ins)]);
               chk("mdl_wb_opcode", {26'd0, ins[31:26]}, 32'd0);
               chk("mdl_wb_addr", {27'd0, wb_addr}, {27'd0, ins[15:11]});
               chk("mdl_wb_data", wb_data, e);
               pend_wb   = 1'b1;
               pend_addr = ins[15:11];
               pend_data = e;
            end
         end
         if (err_illegal) begin
            if (q_acc.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL mdl_err_unexpected actual=1 required=0");
            end else begin
               ins = q_acc.pop_front();
               chk("mdl_err_opcode", {31'd0, ins[31:26] != 6'd0}, 32'd1);
            end
         end
      end
   end

   task automatic cfg_write(input logic [4:0] a, input logic [31:0] d);
      @(negedge clock);
      cfg_we = 1'b1;
      cfg_addr = a;
      cfg_data = d;
      @(negedge clock);
      cfg_we = 1'b0;
   endtask

   task automatic push(input logic [31:0] w);
      int n = 0;
      @(negedge clock);
      in_valid = 1'b1;
      in_instr = w;
      while (!in_ready && n < 50) begin
         @(negedge clock);
         n++;
      end
      chk("push_ready", {31'd0, in_ready}, 32'd1);
      @(negedge clock);
      in_valid = 1'b0;
   endtask

   task automatic wait_pulse(output bit gw, output bit ge);
      gw = 1'b0;
      ge = 1'b0;
      for (int n = 0; n < 40 && !gw && !ge; n++) begin
         @(negedge clock);
         if (wb_valid) gw = 1'b1;
         if (err_illegal) ge = 1'b1;
      end
   endtask

   task automatic wait_idle();
      int left;
      for (int n = 0; n < 500; n++) begin
         @(negedge clock);
         if (!busy && q_acc.size() == 0 && !wb_valid && !err_illegal) break;
      end
      left = q_acc.size();
      chk("idle_busy", {31'd0, busy}, 32'd0);
      chk("idle_queue", left, 32'd0);
      @(negedge clock);
   endtask

   task automatic sweep(input string tag);
      for (int i = 0; i < 32; i++) begin
         @(negedge clock);
         dbg_addr = 5'(i);
         #1;
         chk(tag, dbg_data, m_rf[i]);
      end
      dbg_addr = '0;
   endtask

   initial begin
      bit          gw;
      bit          ge;
      int          t1;
      int          t2;
      int          acc;
      int          stall_at;
      int          nwb0;
      logic [31:0] wv [6];
      logic [31:0] w;
      logic [5:0]  fn;

      tbl[0] = '{32'hDDDDDDDD, 32'h00011040, 1'b0, 5'd2, 32'hBBBBBBBA, 32'hDDDDDDDD};
      tbl[1] = '{32'h40404040, 32'h00011100, 1'b0, 5'd2, 32'h04040400, 32'h40404040};
      tbl[2] = '{32'h80000010, 32'h00011902, 1'b0, 5'd3, 32'h08000001, 32'h80000010};
      tbl[3] = '{32'h80000010, 32'h00012103, 1'b0, 5'd4, 32'hF8000001, 32'h80000010};
      tbl[4] = '{32'h12345678, 32'h00222820, 1'b0, 5'd5, 32'hEDCBA987, 32'h12345678};
      tbl[5] = '{32'h00000003, 32'h00010040, 1'b0, 5'd0, 32'h00000006, 32'h00000003};
      tbl[6] = '{32'h00000001, 32'h8C220000, 1'b1, 5'd0, 32'h00000000, 32'h00000000};

      in_valid = 1'b0;
      in_instr = '0;
      cfg_we   = 1'b0;
      cfg_addr = '0;
      cfg_data = '0;
      dbg_addr = '0;
      repeat (3) @(negedge clock);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_alu_instr", alu_instr, 32'd0);
      chk("rst_alu_gr1", alu_gr1, 32'd0);
      chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
      chk("rst_wb_addr", {27'd0, wb_addr}, 32'd0);
      chk("rst_wb_data", wb_data, 32'd0);
      chk("rst_err", {31'd0, err_illegal}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      reset = 1'b0;

      for (int t = 0; t < 7; t++) begin
         cfg_write(5'd1, tbl[t].r1);
         push(tbl[t].instr);
         wait_pulse(gw, ge);
         chk($sformatf("t%0d_wb", t), {31'd0, gw}, {31'd0, !tbl[t].ill});
         chk($sformatf("t%0d_err", t), {31'd0, ge}, {31'd0, tbl[t].ill});
         if (gw) begin
            chk($sformatf("t%0d_addr", t), {27'd0, wb_addr}, {27'd0, tbl[t].addr});
            chk($sformatf("t%0d_data", t), wb_data, tbl[t].data);
            chk($sformatf("t%0d_gr1", t), alu_gr1, tbl[t].gr1);
            chk($sformatf("t%0d_instr", t), alu_instr, tbl[t].instr);
         end
         wait_idle();
         if (!tbl[t].ill) begin
            dbg_addr = tbl[t].addr;
            #1;
            chk($sformatf("t%0d_dbg", t), dbg_data,
                (tbl[t].addr == 5'd0) ? 32'd0 : tbl[t].data);
         end
      end
      sweep("tbl_sweep");

      cfg_write(5'd0, 32'hFFFFFFFF);
      dbg_addr = 5'd0;
      #1;
      chk("r0_cfg", dbg_data, 32'd0);

      cfg_write(5'd1, 32'h40404040);
      push(32'h00011080);
      push(32'h00011100);
      t1 = -1;
      t2 = -1;
      for (int n = 0; n < 60 && t2 < 0; n++) begin
         @(negedge clock);
         if (wb_valid) begin
            if (t1 < 0) t1 = cyc;
            else t2 = cyc;
         end
      end
      chk("b2b_gap", t2 - t1, LAT + 2);
      wait_idle();
      dbg_addr = 5'd2;
      #1;
      chk("b2b_r2", dbg_data, 32'h04040400);

      for (int k = 0; k < 6; k++)
         wv[k] = 32'h00010000 | (32'(10 + k) << 11) | (32'(k) << 6);
      nwb0 = n_wb;
      acc = 0;
      stall_at = -1;
      @(negedge clock);
      in_valid = 1'b1;
      for (int n = 0; n < 200 && acc < 6; n++) begin
         in_instr = wv[acc];
         if (!in_ready && stall_at < 0) stall_at = acc;
         if (in_ready) acc++;
         @(negedge clock);
      end
      in_valid = 1'b0;
      chk("full_accepted", acc, 6);
      chk("full_stall_at", stall_at, DEPTH + 1);
      wait_idle();
      chk("full_wb_count", n_wb - nwb0, 6);
      sweep("full_sweep");

      cfg_write(5'd1, 32'h00000100);
      push(32'h00011040);
      gw = 1'b0;
      for (int n = 0; n < 40 && !gw; n++) begin
         @(negedge clock);
         gw = wb_valid;
      end
      chk("col_wb_seen", {31'd0, gw}, 32'd1);
      cfg_we = 1'b1;
      cfg_addr = 5'd2;
      cfg_data = 32'h55555555;
      @(negedge clock);
      cfg_we = 1'b0;
      dbg_addr = 5'd2;
      #1;
      chk("col_r2", dbg_data, 32'h00000200);
      wait_idle();

      for (int i = 1; i < 32; i++) cfg_write(5'(i), $urandom);
      for (int k = 0; k < 40; k++) begin
         case ($urandom_range(0, 6))
            0: fn = 6'h00;
            1: fn = 6'h02;
            2: fn = 6'h03;
            3: fn = 6'h20;
            4: fn = 6'h22;
            5: fn = 6'h25;
            default: fn = 6'($urandom_range(0, 63));
         endcase
         w = $urandom;
         w[5:0] = fn;
         w[31:26] = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
         push(w);
         repeat ($urandom_range(0, 2)) @(negedge clock);
      end
      wait_idle();
      sweep("rnd_sweep");

`ifdef RETIRE_CNT_EN
      chk("retire_cnt", retire_cnt, n_ret);
`endif

      push(32'h00011040);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      chk("rst_mid_wb", {31'd0, wb_valid}, 32'd0);
      chk("rst_mid_busy", {31'd0, busy}, 32'd0);
      chk("rst_mid_ready", {31'd0, in_ready}, 32'd1);
      nwb0 = n_wb;
      repeat (LAT + 6) @(negedge clock);
      chk("rst_mid_no_wb", n_wb - nwb0, 0);
      for (int i = 0; i < 32; i++) begin
         @(negedge clock);
         dbg_addr = 5'(i);
         #1;
         chk("rst_mid_dbg", dbg_data, 32'd0);
      end
`ifdef RETIRE_CNT_EN
      chk("rst_retire", retire_cnt, 32'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
